// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Holds the FSM state encoding and the watchdog width helper.
package data_mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
// The pointer register itself lives in the parent.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] sum_s;
  logic [CW-1:0] cand_s;
  logic          hit_s;

  // Scan from the farthest candidate down so the one closest to ptr wins.
  always_comb begin
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    idx    = '0;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr} + CW'(k);
      cand_s = (sum_s >= CW'(NUM_REQ)) ? (sum_s - CW'(NUM_REQ)) : sum_s;
      hit_s  = req_valid[cand_s[IDX_W-1:0]];
      idx    = hit_s ? cand_s[IDX_W-1:0] : idx;
      any    = any | hit_s;
    end
  end

  // One-hot form of the chosen index.
  always_comb begin
    grant = '0;
    if (any) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between NUM_REQ requesters.
// Issues one-cycle strobes, waits for the completion pulse, and times out into an error response.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      in_data_mem,
  output logic                      write_data,
  output logic [ADDR_W-1:0]         adr_data,
  output logic [ADDR_W-1:0]         adr_data_write,
  output logic [DATA_W-1:0]         data_write,
  input  logic [DATA_W-1:0]         data,
  input  logic                      out_data_mem
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  arb_state_e          state_r, state_s;
  logic [IDX_W-1:0]    ptr_r, ptr_s;
  logic [IDX_W-1:0]    gnt_r, gnt_s;
  logic [WD_W-1:0]     wd_r, wd_s;
  logic                is_write_r, is_write_s;
  logic [NUM_REQ-1:0]  req_ready_r, req_ready_s;
  logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_s;
  logic                rsp_err_r, rsp_err_s;
  logic                rd_stb_r, rd_stb_s;
  logic                wr_stb_r, wr_stb_s;
  logic [ADDR_W-1:0]   adr_rd_r, adr_rd_s;
  logic [ADDR_W-1:0]   adr_wr_r, adr_wr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;

  logic [NUM_REQ-1:0]  pick_grant_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_r),
    .grant     (pick_grant_s),
    .idx       (pick_idx_s),
    .any       (pick_any_s)
  );

  // Next-state and next-output logic; strobes and pulses default low every cycle.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    gnt_s       = gnt_r;
    wd_s        = wd_r;
    is_write_s  = is_write_r;
    req_ready_s = '0;
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    rsp_err_s   = 1'b0;
    rd_stb_s    = 1'b0;
    wr_stb_s    = 1'b0;
    adr_rd_s    = adr_rd_r;
    adr_wr_s    = adr_wr_r;
    wdata_s     = wdata_r;
    case (state_r)
      IDLE: begin
        wd_s = '0;
        if (pick_any_s) begin
          state_s     = WAIT;
          gnt_s       = pick_idx_s;
          ptr_s       = (pick_idx_s == LAST_IDX) ? '0 : (pick_idx_s + IDX_W'(1));
          req_ready_s = pick_grant_s;
          is_write_s  = req_write[pick_idx_s];
          if (req_write[pick_idx_s]) begin
            wr_stb_s = 1'b1;
            adr_wr_s = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
            wdata_s  = req_wdata[pick_idx_s*DATA_W +: DATA_W];
          end else begin
            rd_stb_s = 1'b1;
            adr_rd_s = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (out_data_mem) begin
          state_s            = IDLE;
          wd_s               = '0;
          rsp_valid_s[gnt_r] = 1'b1;
          rsp_data_s         = is_write_r ? '0 : data;
        end else if (wd_r == WD_LAST) begin
          // Completion never came: answer with an error so the owner is released.
          state_s            = IDLE;
          wd_s               = '0;
          rsp_valid_s[gnt_r] = 1'b1;
          rsp_err_s          = 1'b1;
        end else begin
          wd_s = wd_r + WD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_r       <= '0;
      wd_r        <= '0;
      is_write_r  <= 1'b0;
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      rd_stb_r    <= 1'b0;
      wr_stb_r    <= 1'b0;
      adr_rd_r    <= '0;
      adr_wr_r    <= '0;
      wdata_r     <= '0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      gnt_r       <= gnt_s;
      wd_r        <= wd_s;
      is_write_r  <= is_write_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
      rd_stb_r    <= rd_stb_s;
      wr_stb_r    <= wr_stb_s;
      adr_rd_r    <= adr_rd_s;
      adr_wr_r    <= adr_wr_s;
      wdata_r     <= wdata_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_data       = rsp_data_r;
  assign rsp_err        = rsp_err_r;
  assign in_data_mem    = rd_stb_r;
  assign write_data     = wr_stb_r;
  assign adr_data       = adr_rd_r;
  assign adr_data_write = adr_wr_r;
  assign data_write     = wdata_r;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Round-robin arbiter that shares the single-port 16x16 data memory between NUM_REQ requesters, e.g. CPU load/store unit and a loader/DMA port. Each requester presents one read or write at a time. The arbiter serialises accesses onto the memory's strobe interface, waits for the memory's one-cycle completion pulse, and routes read data or write acknowledge back to the owning requester. A watchdog converts a missing completion into an error response so no requester hangs.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 4, memory address width
DATA_W, 16, memory data width
TIMEOUT, 8, cycles in WAIT without completion before error response (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending per requester; held until req_ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
req_ready  out  NUM_REQ  one-cycle accept pulse, onehot or zero
rsp_valid  out  NUM_REQ  one-cycle completion pulse to owning requester
rsp_data  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
in_data_mem  out  1  memory read strobe
write_data  out  1  memory write strobe
adr_data  out  ADDR_W  memory read address
adr_data_write  out  ADDR_W  memory write address
data_write  out  DATA_W  memory write data
data  in  DATA_W  memory read data
out_data_mem  in  1  memory completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr pointer 0; watchdog 0. An in-flight access is abandoned with no response.
- All outputs are registered. Strobes are single-cycle pulses and are never held. The memory misbehaves if its read strobe is held.
- FSM states: IDLE, WAIT.
- IDLE, cycle T, any req_valid set:
  - Pick winner i by round robin, searching upward from pointer with wrap.
  - At the edge: latch req_write/addr/wdata of i and grant index g=i; pointer <= (i+1) mod NUM_REQ.
  - In T+1: req_ready[i]=1; either in_data_mem=1 with adr_data=addr, or write_data=1 with adr_data_write=addr and data_write=wdata. State WAIT.
  - No requests: stay IDLE, pointer unchanged.
- WAIT:
  - Strobes and req_ready return to 0 after their one cycle. Watchdog counts cycles spent in WAIT.
  - out_data_mem=1, normally in T+2: in the next cycle (T+3) rsp_valid[g]=1. For a read, rsp_data = data sampled with out_data_mem. For a write, rsp_data = 0. rsp_err=0. Go to IDLE.
  - Watchdog reaches TIMEOUT with no out_data_mem: next cycle rsp_valid[g]=1, rsp_err=1, rsp_data=0. Go to IDLE.
- Latency req_valid to rsp_valid is 3 cycles. Back-to-back throughput is one access per 3 cycles. The IDLE cycle that carries rsp_valid may arbitrate a new request.
- out_data_mem seen in IDLE is a stray pulse: ignored, no response generated.
- Address and data are captured at grant. Requester changes after req_ready have no effect.
- A requester that drops req_valid before req_ready is simply not granted; no error.
- Adr/data outputs hold their last value while strobes are 0.
- NUM_REQ=1 degenerates to a pass-through sequencer; pointer stays 0.

Decomposition:
- Package data_mem_arb_pkg: state enum (IDLE, WAIT), default ADDR_W/DATA_W constants, watchdog width function clog2(TIMEOUT+1).
- Sub-module rr_picker: combinational, inputs req_valid and pointer, outputs onehot grant, index and any. Pointer register stays in the parent.

Test Plan:
- Single read: req0 read addr 2 (mem preloaded 3) -> req_ready[0] at T+1, in_data_mem pulse at T+1, rsp_valid[0] at T+3 with rsp_data=3, rsp_err=0.
- Write then read: req1 write addr 5 data 16'hBEEF, then read addr 5 -> write_data pulse with adr_data_write=5; read returns 16'hBEEF on rsp_valid[1].
- Contention: req0 and req1 held continuously with reads of addr 0/1 -> grants alternate 0,1,0,1; rsp_data 1,2,1,2; one access per 3 cycles.
- Timeout: memory model suppresses out_data_mem -> rsp_valid[g]=1 with rsp_err=1 and rsp_data=0 after TIMEOUT=8 WAIT cycles; next request serviced normally.
- Reset mid-WAIT: rst_n low one cycle after strobe -> all outputs 0 immediately, no rsp_valid; the following request is granted to requester 0 (pointer reset).
- Stray completion: out_data_mem pulse while IDLE -> no rsp_valid, state stays IDLE.
